// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: funct codes, ALUop classes, FSM states
// and the internal operation enum produced by the decoder.
package alu_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  // ALUop 01 and 11 both mean subtract; only 10 consults the funct field.
  function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    op_e op;
    if (alu_op == ALUOP_ADD) begin
      op = OP_ADD;
    end else if (alu_op != ALUOP_FUNCT) begin
      op = OP_SUB;
    end else begin
      case (funct)
        FN_ADD:   op = OP_ADD;
        FN_SUB:   op = OP_SUB;
        FN_AND:   op = OP_AND;
        FN_OR:    op = OP_OR;
        FN_NOR:   op = OP_NOR;
        FN_SLT:   op = OP_SLT;
        FN_SLTU:  op = OP_SLTU;
        FN_SLL:   op = OP_SLL;
        FN_SRL:   op = OP_SRL;
        FN_SRA:   op = OP_SRA;
        FN_MFHI:  op = OP_MFHI;
        FN_MFLO:  op = OP_MFLO;
        FN_MULT:  op = OP_MULT;
        FN_MULTU: op = OP_MULTU;
        FN_DIV:   op = OP_DIV;
        FN_DIVU:  op = OP_DIVU;
        default:  op = OP_ILL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring division on
// operand magnitudes, with the sign correction applied combinationally on the outputs.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [SHW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div_q, div_d;
  logic               div0_q, div0_d;

  logic               is_div, is_signed, sa, sb;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed && a[WIDTH-1];
  assign sb        = is_signed && b[WIDTH-1];
  assign last      = (count_q == '0);

  assign sum    = mq_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
  assign rem_sh = {acc_q, mq_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, mcand_q};

  // acc/mq hold the running {hi,lo} product for multiply and {remainder,quotient} for divide.
  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    mcand_d  = mcand_q;
    a_raw_d  = a_raw_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div_d    = div_q;
    div0_d   = div0_q;
    if (start) begin
      count_d  = SHW'(WIDTH - 1);
      acc_d    = '0;
      mq_d     = sa ? -a : a;
      mcand_d  = sb ? -b : b;
      a_raw_d  = a;
      neg_lo_d = sa ^ sb;
      neg_hi_d = sa;
      div_d    = is_div;
      div0_d   = is_div && (b == '0);
    end else if (step) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      if (div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  always_comb begin
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (div0_q) begin
        hi_res = a_raw_q;
        lo_res = '1;
      end else begin
        hi_res = neg_hi_q ? -acc_q : acc_q;
        lo_res = neg_lo_q ? -mq_q : mq_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      mcand_q  <= '0;
      a_raw_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      mcand_q  <= mcand_d;
      a_raw_q  <= a_raw_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div_q    <= div_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUop/funct, executes single-cycle ops into a registered
// result and hands MULT/DIV to mdu_iter, whose outcome lands in HI/LO.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       functField,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_e              op;
  logic             accept, is_mul, is_div, mdu_start, mdu_step, mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo, alu_res;
  logic             alu_ill;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign op        = decode_op(ALUop, functField);
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign mdu_start = accept && (is_mul || is_div);
  assign mdu_step  = (state_q == MUL) || (state_q == DIV);

  mdu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start),
    .step   (mdu_step),
    .op     (op),
    .a      (a),
    .b      (b),
    .last   (mdu_last),
    .hi_res (mdu_hi),
    .lo_res (mdu_lo)
  );

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_ILL:  alu_ill = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // FIX is the single cycle where HI/LO and the mul/div result become visible.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MUL;
          end else if (is_div) begin
            state_d = DIV;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
          end
        end
      end
      MUL, DIV: begin
        if (mdu_last) state_d = FIX;
      end
      FIX: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        hi_d        = mdu_hi;
        lo_d        = mdu_lo;
        result_d    = mdu_lo;
        zero_d      = (mdu_lo == '0);
        illegal_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed and random requests scored against an
// arithmetic reference model through an expectation queue and a monitor.
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int SH = 5;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          multi;
    int          due;
    string       name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [1:0]    ALUop = 2'b00;
  logic [5:0]    functField = 6'h00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [SH-1:0] shamt = '0;
  logic          in_ready, out_valid, zero, illegal;
  logic [W-1:0]  result, hi, lo;

  exp_t          sb[$];
  int            cycle = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   hi_m = '0;
  logic [31:0]   lo_m = '0;
  logic [5:0]    fnList [16] = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU, F_SLL,
                                 F_SRL, F_SRA, F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

  alu_exec_unit #(.WIDTH(W), .SHW(SH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .functField (functField),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Architectural meaning of each request, using wide integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sh);
    exp_t e;
    logic [63:0] w;
    logic [5:0] f;
    e.res = '0; e.ill = 1'b0; e.multi = 1'b0; e.due = 0; e.name = "";
    if (op == 2'b00) f = F_ADD;
    else if (op[0]) f = F_SUB;
    else f = fn;
    case (f)
      F_ADD:  e.res = av + bv;
      F_SUB:  e.res = av - bv;
      F_AND:  e.res = av & bv;
      F_OR:   e.res = av | bv;
      F_NOR:  e.res = ~(av | bv);
      F_SLT:  e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      F_SLTU: e.res = (av < bv) ? 32'd1 : 32'd0;
      F_SLL:  e.res = bv << sh;
      F_SRL:  e.res = bv >> sh;
      F_SRA:  e.res = $unsigned($signed(bv) >>> sh);
      F_MFHI: e.res = hi_m;
      F_MFLO: e.res = lo_m;
      F_MULT: begin
        w = 64'(longint'($signed(av)) * longint'($signed(bv)));
        hi_m = w[63:32]; lo_m = w[31:0]; e.multi = 1'b1;
      end
      F_MULTU: begin
        w = {32'd0, av} * {32'd0, bv};
        hi_m = w[63:32]; lo_m = w[31:0]; e.multi = 1'b1;
      end
      F_DIV: begin
        e.multi = 1'b1;
        if (bv == 0) begin
          hi_m = av; lo_m = '1;
        end else begin
          w = 64'(longint'($signed(av)) / longint'($signed(bv)));
          lo_m = w[31:0];
          w = 64'(longint'($signed(av)) % longint'($signed(bv)));
          hi_m = w[31:0];
        end
      end
      F_DIVU: begin
        e.multi = 1'b1;
        if (bv == 0) begin
          hi_m = av; lo_m = '1;
        end else begin
          w = {32'd0, av} / {32'd0, bv};
          lo_m = w[31:0];
          w = {32'd0, av} % {32'd0, bv};
          hi_m = w[31:0];
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (e.multi) e.res = lo_m;
    e.zero = (e.res == 32'd0);
    e.hi = hi_m;
    e.lo = lo_m;
    return e;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Waits for in_ready while offering ignored junk, then issues one request at a negedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] av, input logic [31:0] bv,
                               input logic [4:0] sh, input string nm, input bit track);
    exp_t e;
    int guard = 0;
    while (!in_ready) begin
      if (guard > 100) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL %s_ready_timeout: in_ready stayed 0, required 1 within 100 cycles", nm);
        break;
      end
      in_valid = 1'b1; ALUop = 2'b10; functField = F_ADD;
      a = $urandom; b = $urandom;
      @(negedge clk);
      guard++;
    end
    ALUop = op; functField = fn; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    if (track) begin
      e = model(op, fn, av, bv, sh);
      e.due = cycle + (e.multi ? W + 2 : 1);
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL drain_%s: %0d results pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_cycle"}, cycle, e.due);
        checkOutput({e.name, "_result"}, result, e.res);
        checkOutput({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
        checkOutput({e.name, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        checkOutput({e.name, "_hi"}, hi, e.hi);
        checkOutput({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  initial begin
    int lowCnt;
    logic [1:0] rop;
    logic [5:0] rfn;
    int idx;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_zero", {31'd0, zero}, 32'd1);
    checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    applyStimulus(2'b10, F_SUB, 32'd5, 32'd7, 5'd0, "sub_funct", 1'b1);
    applyStimulus(2'b01, F_AND, 32'd5, 32'd7, 5'd0, "sub_aluop01", 1'b1);
    applyStimulus(2'b10, F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt", 1'b1);
    applyStimulus(2'b10, F_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, "sltu", 1'b1);
    applyStimulus(2'b10, F_SRA, 32'd0, 32'h8000_0000, 5'd4, "sra", 1'b1);

    applyStimulus(2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, "mult", 1'b1);
    lowCnt = 0;
    while (!in_ready && lowCnt < 100) begin
      lowCnt++;
      @(negedge clk);
    end
    checkOutput("mult_ready_low_cycles", lowCnt, 32'd33);
    applyStimulus(2'b10, F_MFHI, 32'd0, 32'd0, 5'd0, "mfhi_after_mult", 1'b1);

    applyStimulus(2'b10, F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, "div_neg", 1'b1);
    applyStimulus(2'b10, F_DIVU, 32'd7, 32'd0, 5'd0, "divu_by_zero", 1'b1);
    applyStimulus(2'b10, 6'h3F, 32'd1, 32'd2, 5'd0, "illegal_funct", 1'b1);
    applyStimulus(2'b00, 6'h3F, 32'd1, 32'd2, 5'd0, "aluop00_add", 1'b1);
    waitDrain("directed");

    for (int i = 0; i < 250; i++) begin
      rop = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 18);
      rfn = (idx < 16) ? fnList[idx] : 6'($urandom_range(0, 63));
      applyStimulus(rop, rfn, pickOperand(), pickOperand(), 5'($urandom_range(0, 31)),
                    $sformatf("rnd%0d", i), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    waitDrain("random");

    applyStimulus(2'b10, F_MULTU, $urandom, $urandom, 5'd0, "multu_abort", 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; ALUop = 2'b00; a = 32'd1; b = 32'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    hi_m = '0;
    lo_m = '0;
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge clk);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (W + 4) @(negedge clk);
    checkOutput("abort_hi_later", hi, 32'd0);
    applyStimulus(2'b10, F_ADD, 32'd40, 32'd2, 5'd0, "add_after_abort", 1'b1);
    waitDrain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
